// File: rtl/spi_apb_arbiter.sv
// Two-requester APB arbiter in front of the SPI/XIP flash controller slave port.
// Serialises whole transfers (round-robin or fixed priority) and bounds each access with a timeout.
module spi_apb_arbiter #(
  parameter int prio_mode      = 0,
  parameter int timeout_cycles = 1024,
  parameter int cnt_w          = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        s0_psel,
  input  logic        s0_penable,
  input  logic [31:0] s0_paddr,
  input  logic [2:0]  s0_pprot,
  input  logic        s0_pwrite,
  input  logic [31:0] s0_pwdata,
  input  logic [3:0]  s0_pstrb,
  output logic        s0_pready,
  output logic [31:0] s0_prdata,
  output logic        s0_pslverr,
  input  logic        s1_psel,
  input  logic        s1_penable,
  input  logic [31:0] s1_paddr,
  input  logic [2:0]  s1_pprot,
  input  logic        s1_pwrite,
  input  logic [31:0] s1_pwdata,
  input  logic [3:0]  s1_pstrb,
  output logic        s1_pready,
  output logic [31:0] s1_prdata,
  output logic        s1_pslverr,
  output logic        m_psel,
  output logic        m_penable,
  output logic [31:0] m_paddr,
  output logic [2:0]  m_pprot,
  output logic        m_pwrite,
  output logic [31:0] m_pwdata,
  output logic [3:0]  m_pstrb,
  input  logic        m_pready,
  input  logic [31:0] m_prdata,
  input  logic        m_pslverr,
  output logic        timeout_evt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam bit tmo_en = (timeout_cycles != 0);
  localparam logic [cnt_w-1:0] cnt_last = (timeout_cycles == 0) ? '0 : cnt_w'(timeout_cycles - 1);

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic             pick;
  logic             timeout_hit;
  logic             resp_valid;
  logic             resp_err;
  logic [31:0]      resp_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    timeout_hit  = 1'b0;
    pick         = s1_psel;
    // On a tie, fixed mode always favours s0; round-robin hands it to whoever did not go last.
    if (s0_psel && s1_psel) pick = (prio_mode != 0) ? 1'b0 : ~last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (s0_psel || s1_psel) begin
          state_d      = SETUP;
          grant_d      = pick;
          last_grant_d = pick;
          cnt_d        = '0;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (m_pready) begin
          state_d = IDLE;
        end else if (tmo_en && (cnt_q == cnt_last)) begin
          timeout_hit = 1'b1;
          state_d     = DRAIN;
        end else begin
          cnt_d = cnt_q + cnt_w'(1);
        end
      end
      DRAIN: if (m_pready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_psel    = (state_q != IDLE);
    m_penable = (state_q == ACCESS) || (state_q == DRAIN);
    m_paddr   = '0;
    m_pprot   = '0;
    m_pwrite  = 1'b0;
    m_pwdata  = '0;
    m_pstrb   = '0;
    if (state_q != IDLE) begin
      if (grant_q) begin
        m_paddr  = s1_paddr;
        m_pprot  = s1_pprot;
        m_pwrite = s1_pwrite;
        m_pwdata = s1_pwdata;
        m_pstrb  = s1_pstrb;
      end else begin
        m_paddr  = s0_paddr;
        m_pprot  = s0_pprot;
        m_pwrite = s0_pwrite;
        m_pwdata = s0_pwdata;
        m_pstrb  = s0_pstrb;
      end
    end
    // A timeout answers with an error and zero data; the late downstream reply is swallowed in DRAIN.
    resp_valid  = (state_q == ACCESS) && (m_pready || timeout_hit);
    resp_err    = m_pready ? m_pslverr : 1'b1;
    resp_data   = m_pready ? m_prdata : '0;
    s0_pready   = resp_valid && !grant_q;
    s0_pslverr  = s0_pready && resp_err;
    s0_prdata   = s0_pready ? resp_data : '0;
    s1_pready   = resp_valid && grant_q;
    s1_pslverr  = s1_pready && resp_err;
    s1_prdata   = s1_pready ? resp_data : '0;
    timeout_evt = timeout_hit;
  end

  // The granted requester must hold its transfer until it has been answered.
  a_hold_psel : assert property (@(posedge clock) disable iff (reset)
    ((state_q == SETUP) || (state_q == ACCESS)) |-> (grant_q ? s1_psel : s0_psel));
  a_hold_penable : assert property (@(posedge clock) disable iff (reset)
    (state_q == ACCESS) |-> (grant_q ? s1_penable : s0_penable));

endmodule

// File: tb/tb_spi_apb_arbiter.sv
// Bench for spi_apb_arbiter: a round-robin/timeout-8 instance and a fixed-priority/timeout-1
// instance, each checked every cycle against a transaction-level model plus literal expectations.
module tb_spi_apb_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
  } xfer_t;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    int          start;
    logic [31:0] maddr;
    logic        mwrite;
  } log_t;

  logic clock = 1'b0;
  logic reset;

  logic        s_psel    [2][2];
  logic        s_penable [2][2];
  logic [31:0] s_paddr   [2][2];
  logic [2:0]  s_pprot   [2][2];
  logic        s_pwrite  [2][2];
  logic [31:0] s_pwdata  [2][2];
  logic [3:0]  s_pstrb   [2][2];
  logic        s_pready  [2][2];
  logic [31:0] s_prdata  [2][2];
  logic        s_pslverr [2][2];
  logic        m_psel    [2];
  logic        m_penable [2];
  logic [31:0] m_paddr   [2];
  logic [2:0]  m_pprot   [2];
  logic        m_pwrite  [2];
  logic [31:0] m_pwdata  [2];
  logic [3:0]  m_pstrb   [2];
  logic        m_pready  [2];
  logic [31:0] m_prdata  [2];
  logic        m_pslverr [2];
  logic        timeout_evt [2];

  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    spi_apb_arbiter #(
      .prio_mode(g),
      .timeout_cycles((g == 0) ? 8 : 1),
      .cnt_w(16)
    ) u_dut (
      .clock(clock), .reset(reset),
      .s0_psel(s_psel[g][0]), .s0_penable(s_penable[g][0]), .s0_paddr(s_paddr[g][0]),
      .s0_pprot(s_pprot[g][0]), .s0_pwrite(s_pwrite[g][0]), .s0_pwdata(s_pwdata[g][0]),
      .s0_pstrb(s_pstrb[g][0]), .s0_pready(s_pready[g][0]), .s0_prdata(s_prdata[g][0]),
      .s0_pslverr(s_pslverr[g][0]),
      .s1_psel(s_psel[g][1]), .s1_penable(s_penable[g][1]), .s1_paddr(s_paddr[g][1]),
      .s1_pprot(s_pprot[g][1]), .s1_pwrite(s_pwrite[g][1]), .s1_pwdata(s_pwdata[g][1]),
      .s1_pstrb(s_pstrb[g][1]), .s1_pready(s_pready[g][1]), .s1_prdata(s_prdata[g][1]),
      .s1_pslverr(s_pslverr[g][1]),
      .m_psel(m_psel[g]), .m_penable(m_penable[g]), .m_paddr(m_paddr[g]), .m_pprot(m_pprot[g]),
      .m_pwrite(m_pwrite[g]), .m_pwdata(m_pwdata[g]), .m_pstrb(m_pstrb[g]),
      .m_pready(m_pready[g]), .m_prdata(m_prdata[g]), .m_pslverr(m_pslverr[g]),
      .timeout_evt(timeout_evt[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model: whether a transfer is in flight, who owns it, how many cycles since grant, draining or not.
  bit mdl_busy [2];
  bit mdl_drain [2];
  int mdl_owner [2];
  int mdl_age [2];
  int mdl_last [2];

  xfer_t req_q [4][$];
  bit    req_act [4];
  bit    got_rdy [4];
  int    start_cyc [4];
  log_t  resp_log [2][$];

  int          lat [2];
  logic [31:0] rdv [2];
  logic        errv [2];
  int          acc_cnt [2];
  int          psel_cnt [2];
  int          tev_cnt [2];
  logic        smp_psel [2];

  function automatic int prio_of(input int d);
    return d;
  endfunction

  function automatic int tmo_of(input int d);
    return (d == 0) ? 8 : 1;
  endfunction

  function automatic log_t get_log(input int d, input int k);
    log_t empty;
    empty = '{port: -1, rdata: 32'hffffffff, err: 1'bx, cyc: -1, start: 0, maddr: '0, mwrite: 1'bx};
    if (k < resp_log[d].size()) return resp_log[d][k];
    return empty;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        mdl_busy[d] = 0; mdl_drain[d] = 0; mdl_age[d] = 0; mdl_owner[d] = 0; mdl_last[d] = 1;
      end else if (!mdl_busy[d]) begin
        if (s_psel[d][0] || s_psel[d][1]) begin
          if (s_psel[d][0] && s_psel[d][1]) mdl_owner[d] = (prio_of(d) != 0) ? 0 : 1 - mdl_last[d];
          else mdl_owner[d] = s_psel[d][1] ? 1 : 0;
          mdl_last[d] = mdl_owner[d];
          mdl_busy[d] = 1; mdl_drain[d] = 0; mdl_age[d] = 0;
        end
      end else if (mdl_drain[d]) begin
        if (m_pready[d]) mdl_busy[d] = 0;
      end else if (mdl_age[d] == 0) begin
        mdl_age[d] = 1;
      end else if (m_pready[d]) begin
        mdl_busy[d] = 0;
      end else if (tmo_of(d) != 0 && mdl_age[d] == tmo_of(d)) begin
        mdl_drain[d] = 1;
      end else begin
        mdl_age[d]++;
      end
    end
  endtask

  task automatic check_output();
    int o, idx;
    bit in_acc, to, rsp, er;
    string u;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      u = $sformatf("u%0d", d);
      o = mdl_owner[d];
      in_acc = mdl_busy[d] && !mdl_drain[d] && (mdl_age[d] >= 1);
      to = in_acc && !m_pready[d] && (tmo_of(d) != 0) && (mdl_age[d] == tmo_of(d));
      rsp = in_acc && (m_pready[d] || to);
      chk({u, ".m_psel"}, m_psel[d], mdl_busy[d]);
      chk({u, ".m_penable"}, m_penable[d], mdl_busy[d] && (mdl_drain[d] || mdl_age[d] >= 1));
      chk({u, ".m_paddr"}, m_paddr[d], mdl_busy[d] ? s_paddr[d][o] : 32'h0);
      chk({u, ".m_pprot"}, m_pprot[d], mdl_busy[d] ? s_pprot[d][o] : 3'h0);
      chk({u, ".m_pwrite"}, m_pwrite[d], mdl_busy[d] ? s_pwrite[d][o] : 1'b0);
      chk({u, ".m_pwdata"}, m_pwdata[d], mdl_busy[d] ? s_pwdata[d][o] : 32'h0);
      chk({u, ".m_pstrb"}, m_pstrb[d], mdl_busy[d] ? s_pstrb[d][o] : 4'h0);
      chk({u, ".timeout_evt"}, timeout_evt[d], to);
      for (int p = 0; p < 2; p++) begin
        er = rsp && (o == p);
        chk($sformatf("%s.s%0d_pready", u, p), s_pready[d][p], er);
        chk($sformatf("%s.s%0d_pslverr", u, p), s_pslverr[d][p], er ? (m_pready[d] ? m_pslverr[d] : 1'b1) : 1'b0);
        chk($sformatf("%s.s%0d_prdata", u, p), s_prdata[d][p], (er && m_pready[d]) ? m_prdata[d] : 32'h0);
      end
      if (m_psel[d]) psel_cnt[d]++;
      if (timeout_evt[d]) tev_cnt[d]++;
      smp_psel[d] = m_psel[d];
      for (int p = 0; p < 2; p++) begin
        idx = d * 2 + p;
        if (req_act[idx] && s_pready[d][p]) begin
          got_rdy[idx] = 1;
          resp_log[d].push_back('{port: p, rdata: s_prdata[d][p], err: s_pslverr[d][p], cyc: cyc,
                                  start: start_cyc[idx], maddr: m_paddr[d], mwrite: m_pwrite[d]});
        end
      end
    end
  endtask

  task automatic clear_port(input int d, input int p);
    s_psel[d][p] = 0; s_penable[d][p] = 0; s_paddr[d][p] = '0; s_pprot[d][p] = '0;
    s_pwrite[d][p] = 0; s_pwdata[d][p] = '0; s_pstrb[d][p] = '0;
  endtask

  // Requesters hold each transfer until answered; the downstream slave answers after lat[] enable cycles.
  task automatic apply_stimulus();
    int idx;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        idx = d * 2 + p;
        if (req_act[idx] && got_rdy[idx]) begin
          void'(req_q[idx].pop_front());
          req_act[idx] = 0;
        end
        got_rdy[idx] = 0;
        if (!req_act[idx] && req_q[idx].size() > 0) begin
          req_act[idx] = 1;
          start_cyc[idx] = cyc + 1;
          s_psel[d][p] = 1; s_penable[d][p] = 0;
          s_paddr[d][p] = req_q[idx][0].addr; s_pwrite[d][p] = req_q[idx][0].write;
          s_pwdata[d][p] = req_q[idx][0].wdata; s_pstrb[d][p] = req_q[idx][0].strb;
          s_pprot[d][p] = req_q[idx][0].prot;
        end else if (req_act[idx]) begin
          s_penable[d][p] = 1;
        end else begin
          clear_port(d, p);
        end
      end
      if (m_psel[d] && m_penable[d]) acc_cnt[d]++;
      else acc_cnt[d] = 0;
      m_pready[d] = (acc_cnt[d] == lat[d]);
      m_prdata[d] = rdv[d];
      m_pslverr[d] = errv[d];
    end
  endtask

  task automatic step();
    @(negedge clock);
    check_output();
    @(posedge clock);
    model_update();
    #1;
    apply_stimulus();
  endtask

  task automatic push(input int d, input int p, input logic [31:0] addr, input logic write,
                      input logic [31:0] wdata, input logic [3:0] strb);
    req_q[d * 2 + p].push_back('{addr: addr, write: write, wdata: wdata, strb: strb, prot: 3'b010});
  endtask

  task automatic reset_pulse();
    reset = 1;
    step();
    reset = 0;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        req_q[d * 2 + p].delete();
        req_act[d * 2 + p] = 0;
        got_rdy[d * 2 + p] = 0;
        clear_port(d, p);
      end
      resp_log[d].delete();
      psel_cnt[d] = 0;
      tev_cnt[d] = 0;
    end
  endtask

  task automatic wait_resp(input int d, input int n, input int budget);
    int k = 0;
    while (resp_log[d].size() < n && k < budget) begin
      step();
      k++;
    end
    chk($sformatf("u%0d.resp_count", d), resp_log[d].size(), n);
  endtask

  initial begin
    log_t e;
    int idle_cyc;
    int k;
    reset = 1;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) clear_port(d, p);
      lat[d] = 1; rdv[d] = '0; errv[d] = 0; acc_cnt[d] = 0;
      m_pready[d] = 0; m_prdata[d] = '0; m_pslverr[d] = 0;
    end
    @(posedge clock);
    model_update();
    #1;
    apply_stimulus();
    reset_pulse();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("u%0d.rst_m_psel", d), m_psel[d], 0);
      chk($sformatf("u%0d.rst_m_penable", d), m_penable[d], 0);
      chk($sformatf("u%0d.rst_s0_pready", d), s_pready[d][0], 0);
      chk($sformatf("u%0d.rst_timeout_evt", d), timeout_evt[d], 0);
    end

    // s0 read alone, three ACCESS cycles
    lat[0] = 3; rdv[0] = 32'hdeadbeef;
    push(0, 0, 32'h1c000100, 0, 32'h0, 4'h0);
    wait_resp(0, 1, 30);
    repeat (3) step();
    e = get_log(0, 0);
    chk("single.port", e.port, 0);
    chk("single.rdata", e.rdata, 32'hdeadbeef);
    chk("single.err", e.err, 0);
    chk("single.latency", e.cyc - e.start, 4);
    chk("single.psel_cycles", psel_cnt[0], 4);
    chk("single.s1_untouched", resp_log[0].size(), 1);

    // Round-robin alternation on u0, fixed-priority starvation on u1
    reset_pulse();
    lat[0] = 1; lat[1] = 1; rdv[0] = 32'h11112222; rdv[1] = 32'h33334444;
    for (int i = 0; i < 2; i++) begin
      push(0, 0, 32'h1c000200, 0, 32'h0, 4'h0);
      push(0, 1, 32'h10001000, 0, 32'h0, 4'h0);
    end
    for (int i = 0; i < 3; i++) push(1, 0, 32'h1c000300, 0, 32'h0, 4'h0);
    push(1, 1, 32'h10001004, 0, 32'h0, 4'h0);
    wait_resp(0, 4, 40);
    wait_resp(1, 4, 40);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr.order%0d", i), get_log(0, i).port, i % 2);
      chk($sformatf("fp.order%0d", i), get_log(1, i).port, (i == 3) ? 1 : 0);
    end
    for (int i = 1; i < 4; i++) chk($sformatf("rr.gap%0d", i), get_log(0, i).cyc - get_log(0, i - 1).cyc, 3);
    chk("rr.first_latency", get_log(0, 0).cyc - get_log(0, 0).start, 2);

    // Timeouts: u0 limit 8 with a 20-cycle slave and a pending s1; u1 limit 1
    reset_pulse();
    lat[0] = 20; rdv[0] = 32'ha5a5a5a5; lat[1] = 3; rdv[1] = 32'h5a5a5a5a;
    push(0, 0, 32'h1c000400, 0, 32'h0, 4'h0);
    push(1, 0, 32'h1c000500, 0, 32'h0, 4'h0);
    step(); step();
    push(0, 1, 32'h10001008, 0, 32'h0, 4'h0);
    wait_resp(0, 1, 30);
    e = get_log(0, 0);
    chk("tmo8.port", e.port, 0);
    chk("tmo8.err", e.err, 1);
    chk("tmo8.rdata", e.rdata, 32'h0);
    chk("tmo8.latency", e.cyc - e.start, 9);
    k = 0;
    while (smp_psel[0] && k < 30) begin
      step();
      k++;
    end
    chk("tmo8.drain_done", smp_psel[0], 0);
    chk("tmo8.psel_cycles", psel_cnt[0], 21);
    idle_cyc = cyc;
    lat[0] = 2;
    wait_resp(0, 2, 20);
    e = get_log(0, 1);
    chk("tmo8.s1_port", e.port, 1);
    chk("tmo8.s1_cycle", e.cyc, idle_cyc + 3);
    chk("tmo8.s1_err", e.err, 0);
    chk("tmo8.s1_rdata", e.rdata, 32'ha5a5a5a5);
    chk("tmo8.evt_count", tev_cnt[0], 1);
    e = get_log(1, 0);
    chk("tmo1.err", e.err, 1);
    chk("tmo1.latency", e.cyc - e.start, 2);
    chk("tmo1.evt_count", tev_cnt[1], 1);

    // s1 write, immediate ready, then the same with a slave error
    reset_pulse();
    lat[0] = 1; rdv[0] = 32'h13572468; errv[0] = 0;
    push(0, 1, 32'h10001014, 1, 32'h0, 4'hf);
    wait_resp(0, 1, 20);
    e = get_log(0, 0);
    chk("wr.port", e.port, 1);
    chk("wr.latency", e.cyc - e.start, 2);
    chk("wr.m_paddr", e.maddr, 32'h10001014);
    chk("wr.m_pwrite", e.mwrite, 1);
    chk("wr.err", e.err, 0);
    errv[0] = 1;
    push(0, 1, 32'h10001014, 1, 32'h0, 4'hf);
    wait_resp(0, 2, 20);
    chk("wr.slverr", get_log(0, 1).err, 1);
    errv[0] = 0;

    // Reset while in ACCESS abandons the transfer; a fresh request is served normally
    reset_pulse();
    lat[0] = 10; rdv[0] = 32'hcafef00d;
    push(0, 0, 32'h1c000600, 0, 32'h0, 4'h0);
    repeat (3) step();
    chk("rst.in_access", m_penable[0], 1);
    reset_pulse();
    chk("rst.m_psel", m_psel[0], 0);
    chk("rst.m_penable", m_penable[0], 0);
    chk("rst.s0_pready", s_pready[0][0], 0);
    chk("rst.m_paddr", m_paddr[0], 32'h0);
    step(); step();
    chk("rst.no_response", resp_log[0].size(), 0);
    lat[0] = 1;
    push(0, 0, 32'h1c000700, 0, 32'h0, 4'h0);
    wait_resp(0, 1, 20);
    e = get_log(0, 0);
    chk("rst.new_rdata", e.rdata, 32'hcafef00d);
    chk("rst.new_latency", e.cyc - e.start, 2);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_apb_arbiter.md
Name: spi_apb_arbiter

Overview:
- Two-requester APB arbiter that shares the single APB slave port of the SPI/XIP flash controller.
- Requester 0 is the instruction-fetch XIP path; requester 1 is the data/MMIO path (flash reads plus SPI register accesses).
- Serialises whole APB transfers with round-robin or fixed priority.
- Bounds each downstream access with a timeout; on expiry it answers the requester with an error and drains the downstream transfer.

Parameters:
- prio_mode, 0: 0 = round-robin; 1 = fixed priority, s0 always wins ties.
- timeout_cycles, 1024: maximum ACCESS-state cycles before the error response; 0 disables the timeout.
- cnt_w, 16: timeout counter width. Requires timeout_cycles < 2^cnt_w.

Ports:
- clock, input, 1: sole clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- s0_psel, s1_psel, input, 1: upstream select.
- s0_penable, s1_penable, input, 1: upstream enable.
- s0_paddr, s1_paddr, input, 32: upstream address.
- s0_pprot, s1_pprot, input, 3: upstream protection.
- s0_pwrite, s1_pwrite, input, 1: upstream write.
- s0_pwdata, s1_pwdata, input, 32: upstream write data.
- s0_pstrb, s1_pstrb, input, 4: upstream strobes.
- s0_pready, s1_pready, output, 1: upstream ready.
- s0_prdata, s1_prdata, output, 32: upstream read data.
- s0_pslverr, s1_pslverr, output, 1: upstream error.
- m_psel, m_penable, output, 1: downstream select/enable.
- m_paddr, output, 32: downstream address.
- m_pprot, output, 3: downstream protection.
- m_pwrite, output, 1: downstream write.
- m_pwdata, output, 32: downstream write data.
- m_pstrb, output, 4: downstream strobes.
- m_pready, input, 1: downstream ready.
- m_prdata, input, 32: downstream read data.
- m_pslverr, input, 1: downstream error.
- timeout_evt, output, 1: one-cycle pulse when a timeout fires.

Behaviour:
- States:
  - IDLE: m_psel=0, m_penable=0.
  - SETUP: m_psel=1, m_penable=0.
  - ACCESS: m_psel=1, m_penable=1.
  - DRAIN: m_psel=1, m_penable=1, response discarded.
- Reset (synchronous):
  - Next edge: state=IDLE, grant=0, last_grant=1, counter=0.
  - All outputs 0: s*_pready, s*_pslverr, s*_prdata, m_psel, m_penable, timeout_evt.
  - m_paddr/m_pwdata/m_pstrb/m_pprot/m_pwrite read 0 while IDLE.
  - Reset mid-transfer abandons both sides; no response is produced.
- Grant in IDLE:
  - Requests are s0_psel and s1_psel.
  - Only one asserted: grant that one.
  - Both asserted: prio_mode=0 grants ~last_grant; prio_mode=1 grants 0.
  - grant and last_grant register on the IDLE->SETUP edge.
  - No request: stay in IDLE.
- SETUP -> ACCESS unconditionally, one cycle.
- In SETUP/ACCESS/DRAIN, m_paddr/pwrite/pwdata/pstrb/pprot are combinational copies of the granted requester's inputs. APB guarantees these are stable while psel is held.
- ACCESS:
  - m_pready=1: the granted port sees s_pready=1, s_prdata=m_prdata, s_pslverr=m_pslverr in the same cycle (combinational). Next state IDLE.
  - No m_pready and timeout_cycles!=0 and counter==timeout_cycles-1: the granted port sees s_pready=1, s_pslverr=1, s_prdata=0. timeout_evt=1 that cycle. Next state DRAIN.
  - Otherwise the counter increments. The counter clears on entry to SETUP.
- DRAIN:
  - Hold m_psel/m_penable until m_pready, then IDLE.
  - Upstream ports see pready=0 throughout.
  - No new grant is made until DRAIN exits.
- Non-granted port: pready=0, pslverr=0, prdata=0 at all times.
- Latency:
  - Upstream psel seen at edge T (IDLE): SETUP at T+1, ACCESS at T+2.
  - Earliest s_pready is at T+2, i.e. at least one wait state versus a direct connection.
- Back-to-back:
  - Minimum one IDLE cycle between downstream transfers.
  - A requester that completes and immediately re-asserts psel loses to a waiting peer in round-robin mode.
- A requester dropping psel while granted before pready is a protocol violation; behaviour is undefined, and the assertion in simulation flags it.
- timeout_cycles=1 with no m_pready: error at T+2, timeout_evt pulses once.
- Fixed-priority mode may starve s1; this is intentional, with the timeout as the only guard.

Test Plan:
- s0 read 0x1c000100 alone, m_pready after 3 ACCESS cycles, m_prdata=0xdeadbeef -> s0_pready high 1 cycle with s0_prdata=0xdeadbeef; s1_pready stays 0; m_psel high 4 cycles total.
- s0 and s1 assert psel same cycle, prio_mode=0, after reset -> s0 granted first, then s1. Repeat both continuously for 4 transfers -> grants alternate 0,1,0,1.
- prio_mode=1, s0 requests back-to-back while s1 is held requesting -> s0 always granted; s1 never served.
- timeout_cycles=8, m_pready held 0 for 20 cycles -> 8th ACCESS cycle gives s_pready=1, s_pslverr=1, s_prdata=0, timeout_evt pulse. m_psel stays high until m_pready at cycle 20. A pending s1 request is granted only after that.
- s1 write 0x10001014 data 0x0 strb 0xf, m_pready=1 immediately -> m_pwrite=1, m_paddr=0x10001014, s1_pready at T+2. m_pslverr=1 in the same scenario -> s1_pslverr=1.
- reset asserted during ACCESS -> next edge all outputs 0, state IDLE. A new s0 request after reset is served normally.
